// File: rtl/morpher_refill_pkg.sv
// Shared constants and types for the morpher line-refill sequencer.
//   - Line and beat geometry (32-byte line, four 8-byte beats).
//   - Line-align mask applied to the latched request address.
//   - Sequencer state encoding and the latched request payload.
package morpher_refill_pkg;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned BEATS      = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned BEAT_IDX_W = 2;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned BEAT_W     = BEAT_BYTES * 8;

  // Bit position of the critical-beat index inside a byte address
  localparam int unsigned CRIT_LSB   = 3;

  // Clears the byte-within-line offset of an address
  localparam logic [ADDR_W-1:0] LINE_ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Request fields held for the lifetime of one refill
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_taint;
  } req_lat_t;

endpackage

// File: rtl/morpher_line_serializer.sv
// Line buffer and beat serializer for one refilled cache line.
// Holds the captured 256-bit line plus its taint, and walks a wrapping beat
// pointer starting at the critical beat.
//   clock, reset      : clock and synchronous active-low reset
//   init_i/init_ptr_i : load the starting beat and clear the beat counter
//   capture_i         : latch line_i/line_taint_i into the buffers
//   advance_i         : one beat has been transferred
//   beat_*_o          : current beat data, taint, index and last flag
module morpher_line_serializer
  import morpher_refill_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init_i,
  input  logic [BEAT_IDX_W-1:0] init_ptr_i,
  input  logic                  capture_i,
  input  logic [LINE_W-1:0]     line_i,
  input  logic [LINE_W-1:0]     line_taint_i,
  input  logic                  advance_i,
  output logic [BEAT_W-1:0]     beat_data_o,
  output logic [BEAT_W-1:0]     beat_taint_o,
  output logic [BEAT_IDX_W-1:0] beat_idx_o,
  output logic                  beat_last_o
);

  logic [LINE_W-1:0]     data_q, data_d;
  logic [LINE_W-1:0]     taint_q, taint_d;
  logic [BEAT_IDX_W-1:0] ptr_q, ptr_d;
  logic [BEAT_IDX_W-1:0] count_q, count_d;

  // Next-state for buffers and beat pointer/counter
  always_comb begin
    data_d  = data_q;
    taint_d = taint_q;
    ptr_d   = ptr_q;
    count_d = count_q;

    if (init_i) begin
      ptr_d   = init_ptr_i;
      count_d = '0;
    end else if (advance_i) begin
      // Pointer is exactly BEAT_IDX_W wide so 3 -> 0 wraps naturally
      ptr_d   = ptr_q + BEAT_IDX_W'(1);
      count_d = count_q + BEAT_IDX_W'(1);
    end

    if (capture_i) begin
      data_d  = line_i;
      taint_d = line_taint_i;
    end
  end

  // State registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q  <= '0;
      taint_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      taint_q <= taint_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Beat mux driven purely from registers
  assign beat_data_o  = data_q[BEAT_W*ptr_q +: BEAT_W];
  assign beat_taint_o = taint_q[BEAT_W*ptr_q +: BEAT_W];
  assign beat_idx_o   = ptr_q;
  assign beat_last_o  = (count_q == BEAT_IDX_W'(BEATS - 1));

endmodule

// File: rtl/morpher_refill_sequencer.sv
// Line-refill front end for the memory morpher.
// Accepts one refill request, issues a single-cycle line read to the morpher,
// captures the returned line and streams it back critical-word-first as four
// 64-bit beats under a ready/valid handshake.
//   clock, reset            : clock and synchronous active-low reset
//   req_*                   : core-side request (valid/ready, addr, taint, id)
//   mm_*                    : morpher read strobe, address, taint and data
//   resp_*                  : beat stream (valid/ready, data, taint, id, beat, last)
//   busy                    : a refill is in flight
module morpher_refill_sequencer
  import morpher_refill_pkg::*;
#(
  parameter int unsigned ID_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_addr_taint,
  input  logic [ID_W-1:0]   req_id,
  output logic              mm_valid,
  output logic              mm_valid_taint,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [ADDR_W-1:0] mm_addr_taint,
  output logic [LINE_W-1:0] mm_data_in,
  output logic [LINE_W-1:0] mm_data_in_taint,
  input  logic [LINE_W-1:0] mm_data_out,
  input  logic [LINE_W-1:0] mm_data_out_taint,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [BEAT_W-1:0] resp_data,
  output logic [BEAT_W-1:0] resp_data_taint,
  output logic [ID_W-1:0]   resp_id,
  output logic [1:0]        resp_beat,
  output logic              resp_last,
  output logic              busy
);

  state_e    state_q, state_d;
  req_lat_t  req_q;
  logic [ID_W-1:0] id_q;

  logic accept;
  logic capture;
  logic advance;
  logic addr_tainted;

  logic [BEAT_W-1:0]     beat_data;
  logic [BEAT_W-1:0]     beat_taint;
  logic [BEAT_IDX_W-1:0] beat_idx;
  logic                  beat_last;

  assign addr_tainted = |req_q.addr_taint;

  // Next-state and handshake/strobe decode
  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    capture         = 1'b0;
    advance         = 1'b0;
    req_ready       = 1'b0;
    mm_valid        = 1'b0;
    resp_valid      = 1'b0;
    resp_data       = '0;
    resp_data_taint = '0;
    resp_beat       = '0;
    resp_last       = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Morpher samples mid-cycle; line is captured at the closing edge
        mm_valid = 1'b1;
        capture  = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        resp_valid      = 1'b1;
        resp_data       = beat_data;
        resp_data_taint = beat_taint;
        resp_beat       = beat_idx;
        resp_last       = beat_last;
        if (resp_ready) begin
          advance = 1'b1;
          if (beat_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and request latch
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.addr       <= req_addr;
        req_q.addr_taint <= req_addr_taint;
        id_q             <= req_id;
      end
    end
  end

  // Morpher-side fields hold their last request value between refills
  assign mm_valid_taint   = addr_tainted;
  assign mm_addr          = req_q.addr & LINE_ALIGN_MASK;
  assign mm_addr_taint    = req_q.addr_taint;
  assign mm_data_in       = '0;
  assign mm_data_in_taint = {LINE_W{addr_tainted}};

  assign resp_id = id_q;
  assign busy    = (state_q != IDLE);

  morpher_line_serializer u_serializer (
    .clock        (clock),
    .reset        (reset),
    .init_i       (accept),
    .init_ptr_i   (req_addr[CRIT_LSB +: BEAT_IDX_W]),
    .capture_i    (capture),
    .line_i       (mm_data_out),
    .line_taint_i (mm_data_out_taint),
    .advance_i    (advance),
    .beat_data_o  (beat_data),
    .beat_taint_o (beat_taint),
    .beat_idx_o   (beat_idx),
    .beat_last_o  (beat_last)
  );

endmodule

// File: tb/tb_morpher_refill_sequencer.sv
// Bench for morpher_refill_sequencer: morpher memory model where byte a holds
// a[7:0], a beat scoreboard filled on request accept and drained on every
// resp handshake, plus per-scenario timing checks.
module tb_morpher_refill_sequencer;

  localparam int unsigned ID_W = 4;

  logic              clock;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic [63:0]       req_addr_taint;
  logic [ID_W-1:0]   req_id;
  logic              mm_valid;
  logic              mm_valid_taint;
  logic [63:0]       mm_addr;
  logic [63:0]       mm_addr_taint;
  logic [255:0]      mm_data_in;
  logic [255:0]      mm_data_in_taint;
  logic [255:0]      mm_data_out;
  logic [255:0]      mm_data_out_taint;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_data;
  logic [63:0]       resp_data_taint;
  logic [ID_W-1:0]   resp_id;
  logic [1:0]        resp_beat;
  logic              resp_last;
  logic              busy;

  morpher_refill_sequencer #(.ID_W(ID_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_addr_taint    (req_addr_taint),
    .req_id            (req_id),
    .mm_valid          (mm_valid),
    .mm_valid_taint    (mm_valid_taint),
    .mm_addr           (mm_addr),
    .mm_addr_taint     (mm_addr_taint),
    .mm_data_in        (mm_data_in),
    .mm_data_in_taint  (mm_data_in_taint),
    .mm_data_out       (mm_data_out),
    .mm_data_out_taint (mm_data_out_taint),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .resp_data_taint   (resp_data_taint),
    .resp_id           (resp_id),
    .resp_beat         (resp_beat),
    .resp_last         (resp_last),
    .busy              (busy)
  );

  typedef struct {
    logic [63:0] data;
    logic [63:0] taint;
    logic [6:0]  meta;   // {beat, last, id}
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int mm_pulses = 0;
  bit stalled = 0;
  logic [63:0] held_d, held_t;
  logic [6:0]  held_m;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [255:0] mem_line(input logic [63:0] a);
    logic [255:0] l;
    logic [63:0]  base;
    base = a & ~64'h1F;
    for (int i = 0; i < 32; i++) l[i*8 +: 8] = 8'(base + 64'(i));
    return l;
  endfunction

  function automatic logic [63:0] beat_taint(input int b);
    return 64'h0123_4567_89AB_CDEF ^ (64'(b + 1) * 64'h0000_1111_0000_1111);
  endfunction

  // Morpher model: answers at the negedge of the strobe cycle, garbage otherwise
  always @(negedge clock) begin
    if (mm_valid) begin
      mm_data_out = mem_line(mm_addr & 64'h7FFF_FFFF);
      for (int b = 0; b < 4; b++)
        mm_data_out_taint[b*64 +: 64] = mm_valid_taint ? beat_taint(b) : 64'h0;
    end else begin
      for (int w = 0; w < 8; w++) begin
        mm_data_out[w*32 +: 32]       = $urandom;
        mm_data_out_taint[w*32 +: 32] = $urandom;
      end
    end
  end

  // Scoreboard drain and stall-stability monitor
  always @(negedge clock) begin
    exp_t e;
    if (mm_valid) mm_pulses++;
    if (reset && resp_valid) begin
      if (stalled) begin
        checks++;
        if ({resp_data, resp_data_taint, resp_beat, resp_last, resp_id} !== {held_d, held_t, held_m}) begin
          errors++;
          $display("FAIL stall_stable got=%h/%h/%h required=%h/%h/%h", resp_data, resp_data_taint,
                   {resp_beat, resp_last, resp_id}, held_d, held_t, held_m);
        end
      end
      if (resp_ready) begin
        hs_count++;
        stalled = 0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got beat=%0d data=%h required=no beat", resp_beat, resp_data);
        end else begin
          e = sb.pop_front();
          if (resp_data !== e.data) begin
            errors++;
            $display("FAIL beat_data got=%h required=%h", resp_data, e.data);
          end
          checks++;
          if (resp_data_taint !== e.taint) begin
            errors++;
            $display("FAIL beat_taint got=%h required=%h", resp_data_taint, e.taint);
          end
          checks++;
          if ({resp_beat, resp_last, resp_id} !== e.meta) begin
            errors++;
            $display("FAIL beat_meta got beat/last/id=%0d/%0b/%0d required=%0d/%0b/%0d",
                     resp_beat, resp_last, resp_id, e.meta[6:5], e.meta[4], e.meta[3:0]);
          end
        end
      end else begin
        stalled = 1;
        held_d  = resp_data;
        held_t  = resp_data_taint;
        held_m  = {resp_beat, resp_last, resp_id};
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic push_line(input logic [63:0] a, input logic [63:0] t, input logic [3:0] id);
    logic [255:0] l;
    logic [1:0]   b;
    exp_t         e;
    l = mem_line(a);
    for (int k = 0; k < 4; k++) begin
      b       = a[4:3] + 2'(k);
      e.data  = l[int'(b)*64 +: 64];
      e.taint = (|t) ? beat_taint(int'(b)) : 64'h0;
      e.meta  = {b, (k == 3), id};
      sb.push_back(e);
    end
  endtask

  // Presents a request and returns #1 into the cycle after the accepting edge
  task automatic issue_req(input logic [63:0] a, input logic [63:0] t, input logic [3:0] id, input bit keep);
    int n;
    req_valid      = 1'b1;
    req_addr       = a;
    req_addr_taint = t;
    req_id         = id;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL req_accept_timeout got req_ready=%0b required=1", req_ready);
    end
    push_line(a, t, id);
    @(posedge clock); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_idle got busy=%0b pending=%0d required busy=0 pending=0", tag, busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready_busy got=%b required=10", {req_ready, busy});
    end
    checks++;
    if ({mm_valid, mm_valid_taint, mm_addr, mm_addr_taint} !== '0) begin
      errors++;
      $display("FAIL reset_mm got v=%0b vt=%0b a=%h at=%h required all 0", mm_valid, mm_valid_taint, mm_addr, mm_addr_taint);
    end
    checks++;
    if ({mm_data_in, mm_data_in_taint} !== '0) begin
      errors++;
      $display("FAIL reset_mm_data_in got=%h/%h required 0", mm_data_in, mm_data_in_taint);
    end
    checks++;
    if ({resp_valid, resp_data, resp_data_taint, resp_id, resp_beat, resp_last} !== '0) begin
      errors++;
      $display("FAIL reset_resp got v=%0b d=%h t=%h id=%0d beat=%0d last=%0b required all 0",
               resp_valid, resp_data, resp_data_taint, resp_id, resp_beat, resp_last);
    end
  endtask

  task automatic test_aligned();
    int n;
    resp_ready = 1'b1;
    issue_req(64'h8000_0040, 64'h0, 4'd3, 0);
    checks++;
    if ({mm_valid, mm_addr, resp_valid, req_ready} !== {1'b1, 64'h8000_0040, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL aligned_issue got v=%0b a=%h rv=%0b rr=%0b required 1/80000040/0/0", mm_valid, mm_addr, resp_valid, req_ready);
    end
    @(posedge clock); #1;
    checks++;
    if ({mm_valid, resp_valid, resp_beat, resp_id} !== {1'b0, 1'b1, 2'd0, 4'd3}) begin
      errors++;
      $display("FAIL aligned_first_beat got mv=%0b rv=%0b beat=%0d id=%0d required 0/1/0/3", mm_valid, resp_valid, resp_beat, resp_id);
    end
    checks++;
    if (resp_data !== 64'h4746_4544_4342_4140) begin
      errors++;
      $display("FAIL aligned_first_data got=%h required=4746454443424140", resp_data);
    end
    n = 2;
    while (busy && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL aligned_accept_to_idle got=%0d required=6", n);
    end
    wait_idle("aligned");
  endtask

  task automatic test_wrap();
    resp_ready = 1'b1;
    issue_req(64'h8000_0058, 64'h0, 4'd7, 0);
    checks++;
    if (mm_addr !== 64'h8000_0040) begin
      errors++;
      $display("FAIL wrap_mm_addr got=%h required=80000040", mm_addr);
    end
    @(posedge clock); #1;
    checks++;
    if ({resp_beat, resp_last, resp_data} !== {2'd3, 1'b0, 64'h5F5E_5D5C_5B5A_5958}) begin
      errors++;
      $display("FAIL wrap_first_beat got beat=%0d last=%0b d=%h required 3/0/5f5e5d5c5b5a5958", resp_beat, resp_last, resp_data);
    end
    wait_idle("wrap");
  endtask

  task automatic test_backpressure();
    logic [6:0] pat;
    int hs0;
    pat = 7'b1011001;   // bit i applied in stream cycle i: 1,0,0,1,1,0,1
    resp_ready = 1'b0;
    hs0 = hs_count;
    issue_req(64'h8000_0010, 64'h0, 4'd4, 0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      resp_ready = pat[i];
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_req_ready_cycle%0d got=%0b required=0", i, req_ready);
      end
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    checks++;
    if ({req_ready, busy} !== 2'b10 || hs_count - hs0 != 4) begin
      errors++;
      $display("FAIL bp_done got rr=%0b busy=%0b handshakes=%0d required 1/0/4", req_ready, busy, hs_count - hs0);
    end
    wait_idle("bp");
  endtask

  task automatic test_taint();
    resp_ready = 1'b1;
    issue_req(64'h8000_0020, 64'h1, 4'd5, 0);
    checks++;
    if ({mm_valid_taint, mm_addr_taint} !== {1'b1, 64'h1}) begin
      errors++;
      $display("FAIL taint_mm got vt=%0b at=%h required 1/1", mm_valid_taint, mm_addr_taint);
    end
    checks++;
    if (mm_data_in_taint !== {256{1'b1}} || mm_data_in !== '0) begin
      errors++;
      $display("FAIL taint_data_in got t=%h d=%h required all ones/0", mm_data_in_taint, mm_data_in);
    end
    wait_idle("taint1");
    issue_req(64'h8000_0100, 64'h0, 4'd6, 0);
    checks++;
    if ({mm_valid_taint, mm_addr_taint, mm_data_in_taint} !== '0) begin
      errors++;
      $display("FAIL taint_zero got vt=%0b at=%h dit=%h required 0", mm_valid_taint, mm_addr_taint, mm_data_in_taint);
    end
    wait_idle("taint0");
    checks++;
    if ({mm_valid, mm_addr} !== {1'b0, 64'h8000_0100}) begin
      errors++;
      $display("FAIL mm_hold got v=%0b a=%h required 0/80000100", mm_valid, mm_addr);
    end
  endtask

  task automatic test_reset_mid();
    int hs0;
    resp_ready = 1'b0;
    hs0 = hs_count;
    issue_req(64'h8000_0000, 64'h0, 4'd8, 0);
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({resp_valid, req_ready, busy, mm_valid, resp_last} !== 5'b01000) begin
      errors++;
      $display("FAIL rst_mid_state got rv/rr/busy/mv/last=%b required=01000", {resp_valid, req_ready, busy, mm_valid, resp_last});
    end
    checks++;
    if (hs_count - hs0 != 2 || sb.size() != 2) begin
      errors++;
      $display("FAIL rst_mid_beats got handshakes=%0d pending=%0d required 2/2", hs_count - hs0, sb.size());
    end
    sb.delete();
    reset = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b1;
    issue_req(64'h8000_0060, 64'h0, 4'd9, 0);
    @(posedge clock); #1;
    checks++;
    if ({resp_valid, resp_beat, resp_data} !== {1'b1, 2'd0, 64'h6766_6564_6362_6160}) begin
      errors++;
      $display("FAIL rst_mid_restart got rv=%0b beat=%0d d=%h required 1/0/6766656463626160", resp_valid, resp_beat, resp_data);
    end
    wait_idle("rst_mid");
  endtask

  task automatic test_back_to_back();
    int p0, cyc, last_cyc, acc_cyc;
    resp_ready = 1'b1;
    p0 = mm_pulses;
    issue_req(64'h8000_0080, 64'h0, 4'd1, 1);
    req_addr = 64'h8000_00C8;
    req_id   = 4'd2;
    cyc = 1;
    last_cyc = -1;
    acc_cyc = -1;
    while (acc_cyc < 0 && cyc < 30) begin
      if (req_ready) begin
        acc_cyc = cyc;
      end else begin
        if (resp_valid && resp_ready && resp_last) last_cyc = cyc;
        @(posedge clock); #1;
        cyc++;
      end
    end
    checks++;
    if (acc_cyc < 0 || last_cyc < 0 || acc_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL b2b_accept_cycle got accept=%0d last=%0d required accept=last+1", acc_cyc, last_cyc);
    end
    checks++;
    if (mm_pulses - p0 != 1) begin
      errors++;
      $display("FAIL b2b_single_strobe got=%0d required=1", mm_pulses - p0);
    end
    push_line(64'h8000_00C8, 64'h0, 4'd2);
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_idle("b2b");
    checks++;
    if (mm_pulses - p0 != 2) begin
      errors++;
      $display("FAIL b2b_total_strobes got=%0d required=2", mm_pulses - p0);
    end
  endtask

  initial begin
    reset             = 1'b0;
    req_valid         = 1'b0;
    req_addr          = '0;
    req_addr_taint    = '0;
    req_id            = '0;
    resp_ready        = 1'b1;
    mm_data_out       = '0;
    mm_data_out_taint = '0;
    test_reset();
    test_aligned();
    test_wrap();
    test_backpressure();
    test_taint();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
